// File: rtl/memory_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter_if : requester and memory-side signals of the port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface memory_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_valid;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              mem_timeout_err;

    // Environment side: requesters plus the memory model.
    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
        output mem_rdata, mem_valid,
        input  fetch_valid, fetch_rdata, data_valid, data_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_timeout_err
    );

    // Arbiter side.
    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
        input  mem_rdata, mem_valid,
        output fetch_valid, fetch_rdata, data_valid, data_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter : round-robin sharing of one memory port between fetch
// and data requesters. Optional watchdog enabled by macro MEM_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memory_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  wire logic             clk,
    input  wire logic             reset,
    memory_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_BUSY = 2'd1,
        DATA_BUSY  = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant_data;
    logic              w_last_grant_data_nxt;
    logic              r_mem_req;
    logic              w_mem_req_nxt;
    logic              r_mem_we;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_mem_wdata_nxt;

    logic              w_timeout;
    logic              w_fetch_done;
    logic              w_data_done;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_busy;

    assign w_busy    = (r_state == FETCH_BUSY) || (r_state == DATA_BUSY);
    assign w_timeout = w_busy && !bus.mem_valid && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero outside BUSY, so every grant starts the count afresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (!w_busy) begin
            r_wait_cnt <= '0;
        end else if (!bus.mem_valid && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_fetch_done = (r_state == FETCH_BUSY) && (bus.mem_valid || w_timeout);
    assign w_data_done  = (r_state == DATA_BUSY)  && (bus.mem_valid || w_timeout);

    // A real completion wins over a simultaneous timeout; timeout returns all ones.
    assign bus.fetch_valid     = w_fetch_done;
    assign bus.fetch_rdata     = !w_fetch_done ? '0 : (bus.mem_valid ? bus.mem_rdata : '1);
    assign bus.data_valid      = w_data_done;
    assign bus.data_rdata      = !w_data_done  ? '0 : (bus.mem_valid ? bus.mem_rdata : '1);
    assign bus.mem_timeout_err = w_timeout;

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= IDLE;
            r_last_grant_data <= 1'b1;
            r_mem_req         <= 1'b0;
            r_mem_we          <= 1'b0;
            r_mem_addr        <= '0;
            r_mem_wdata       <= '0;
        end else begin
            r_state           <= w_state_nxt;
            r_last_grant_data <= w_last_grant_data_nxt;
            r_mem_req         <= w_mem_req_nxt;
            r_mem_we          <= w_mem_we_nxt;
            r_mem_addr        <= w_mem_addr_nxt;
            r_mem_wdata       <= w_mem_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt           = r_state;
        w_last_grant_data_nxt = r_last_grant_data;
        w_mem_req_nxt         = r_mem_req;
        w_mem_we_nxt          = r_mem_we;
        w_mem_addr_nxt        = r_mem_addr;
        w_mem_wdata_nxt       = r_mem_wdata;

        case (r_state)
            IDLE: begin
                // On a tie the side that was not served last wins.
                if (bus.fetch_req && (!bus.data_req || r_last_grant_data)) begin
                    w_state_nxt    = FETCH_BUSY;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = bus.fetch_addr;
                end else if (bus.data_req) begin
                    w_state_nxt     = DATA_BUSY;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.data_we;
                    w_mem_addr_nxt  = bus.data_addr;
                    w_mem_wdata_nxt = bus.data_wdata;
                end
            end
            FETCH_BUSY: begin
                if (w_fetch_done) begin
                    w_state_nxt           = RELEASE;
                    w_mem_req_nxt         = 1'b0;
                    w_last_grant_data_nxt = 1'b0;
                end
            end
            DATA_BUSY: begin
                if (w_data_done) begin
                    w_state_nxt           = RELEASE;
                    w_mem_req_nxt         = 1'b0;
                    w_last_grant_data_nxt = 1'b1;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire
